hazard_unit: RTL and testbench

//  Hazard controller for the 5-stage (IF/ID/EX/MEM/WB) 19-bit-instruction datapath.
//  - Shadows destination/flag info of the EX, MEM and WB stages; detects RAW and flag hazards for the instruction in ID.
//  - Drives stall (hold PC and IF_ID), bubble (NOP into ID_EX) and flush (clear IF_ID) to the datapath.
//  - Drives the EX-stage operand forwarding selects to the datapath.

---
 rtl/hazard_unit.sv | 134 +++++++++++++
 tb/tb_hazard_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// ============================================================================
// Module   : hazard_unit
// Function : RAW/flag hazard detection, stall/bubble/flush and EX forwarding
//            selects for the 5-stage 19-bit-instruction pipeline.
//            Optional macro HAZARD_FWD_EN enables operand forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int REG_AW = 3,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic              id_uses_a,
    input  logic              id_uses_b,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_writes_flag,
    input  logic              id_reads_flag,
    input  logic              id_redirect,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] perf_stalls
);

    logic              ex_vld, ex_wr, ex_ld, ex_fw;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_vld, mem_wr;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_vld, wb_wr;
    logic [REG_AW-1:0] wb_rd;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, hit_wb_a, hit_wb_b;
    logic load_use, flag_haz, raw_stall;

    always_comb begin
        hit_ex_a  = ex_vld  & ex_wr  & (ex_rd  == id_rs_a) & id_uses_a & id_valid;
        hit_ex_b  = ex_vld  & ex_wr  & (ex_rd  == id_rs_b) & id_uses_b & id_valid;
        hit_mem_a = mem_vld & mem_wr & (mem_rd == id_rs_a) & id_uses_a & id_valid;
        hit_mem_b = mem_vld & mem_wr & (mem_rd == id_rs_b) & id_uses_b & id_valid;
        hit_wb_a  = wb_vld  & wb_wr  & (wb_rd  == id_rs_a) & id_uses_a & id_valid;
        hit_wb_b  = wb_vld  & wb_wr  & (wb_rd  == id_rs_b) & id_uses_b & id_valid;
    end

    always_comb begin
        load_use = ex_ld & (hit_ex_a | hit_ex_b);
        // C/Z only settle at the end of EX, so a flag consumer must wait one cycle.
        flag_haz = id_reads_flag & ex_vld & ex_fw;
`ifdef HAZARD_FWD_EN
        raw_stall = 1'b0;
`else
        raw_stall = hit_ex_a | hit_ex_b | hit_mem_a | hit_mem_b | hit_wb_a | hit_wb_b;
`endif
        stall  = load_use | flag_haz | raw_stall;
        bubble = stall;
        flush  = id_redirect & id_valid & ~stall & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_vld  <= 1'b0;
            ex_rd   <= '0;
            ex_wr   <= 1'b0;
            ex_ld   <= 1'b0;
            ex_fw   <= 1'b0;
            mem_vld <= 1'b0;
            mem_rd  <= '0;
            mem_wr  <= 1'b0;
            wb_vld  <= 1'b0;
            wb_rd   <= '0;
            wb_wr   <= 1'b0;
        end else begin
            ex_vld  <= id_valid & ~bubble;
            ex_rd   <= id_rd;
            ex_wr   <= id_reg_write;
            ex_ld   <= id_is_load;
            ex_fw   <= id_writes_flag;
            mem_vld <= ex_vld;
            mem_rd  <= ex_rd;
            mem_wr  <= ex_wr;
            wb_vld  <= mem_vld;
            wb_rd   <= mem_rd;
            wb_wr   <= mem_wr;
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] sel_a, sel_b;

    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (hit_ex_a)       sel_a = 2'b01;
        else if (hit_mem_a) sel_a = 2'b10;
        else if (hit_wb_a)  sel_a = 2'b11;
        if (hit_ex_b)       sel_b = 2'b01;
        else if (hit_mem_b) sel_b = 2'b10;
        else if (hit_wb_b)  sel_b = 2'b11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
        end else begin
            fwd_a <= bubble ? 2'b00 : sel_a;
            fwd_b <= bubble ? 2'b00 : sel_b;
        end
    end
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (stall && (perf_stalls != {PERF_W{1'b1}})) begin
            perf_stalls <= perf_stalls + PERF_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes model expectations, a negedge monitor pops and compares.
`default_nettype none

module tb_hazard_unit;

    localparam int PW = 10;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 0, id_uses_a = 0, id_uses_b = 0, id_reg_write = 0;
    logic       id_is_load = 0, id_writes_flag = 0, id_reads_flag = 0, id_redirect = 0;
    logic [2:0] id_rs_a = 0, id_rs_b = 0, id_rd = 0;
    logic       stall, bubble, flush;
    logic [1:0] fwd_a, fwd_b;
    logic [PW-1:0] perf_stalls;

    hazard_unit #(.REG_AW(3), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_writes_flag(id_writes_flag), .id_reads_flag(id_reads_flag),
        .id_redirect(id_redirect), .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid; int rs_a; int rs_b; bit ua; bit ub; int rd;
        bit wr; bit ld; bit wf; bit rf; bit redir;
    } instr_t;
    typedef struct { bit vld; int rd; bit wr; bit ld; bit fw; } slot_t;
    typedef struct { bit st; bit bb; bit fl; int fa; int fb; int perf; } exp_t;

    exp_t   sb[$];
    slot_t  pipe[$];     // index 0 = instruction now in EX, 1 = MEM, 2 = WB
    int     m_fa, m_fb, m_perf, tot_stalls;
    bit     last_stall, last_flush;
    int     tests = 0, fails = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", 32'(stall), 32'(e.st));
            chk("bubble", 32'(bubble), 32'(e.bb));
            chk("flush", 32'(flush), 32'(e.fl));
            chk("fwd_a", 32'(fwd_a), 32'(e.fa));
            chk("fwd_b", 32'(fwd_b), 32'(e.fb));
            chk("perf_stalls", 32'(perf_stalls), 32'(e.perf));
        end
    end

    function automatic void model_clear();
        slot_t z = '{0, 0, 0, 0, 0};
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(z);
        m_fa = 0; m_fb = 0; m_perf = 0;
        last_stall = 0; last_flush = 0;
    endfunction

    // Distance to the youngest in-flight writer of register s, or -1.
    function automatic int producer(instr_t x, int s, bit uses);
        if (!x.valid || !uses) return -1;
        for (int i = 0; i < 3; i++)
            if (pipe[i].vld && pipe[i].wr && pipe[i].rd == s) return i;
        return -1;
    endfunction

    task automatic issue(instr_t x);
        exp_t  e;
        slot_t s;
        int    pa, pb;
        bit    lu, fl, st;
        @(posedge clk);
        #1;
        reset = 1'b0;
        id_valid = x.valid; id_rs_a = 3'(x.rs_a); id_rs_b = 3'(x.rs_b);
        id_uses_a = x.ua; id_uses_b = x.ub; id_rd = 3'(x.rd); id_reg_write = x.wr;
        id_is_load = x.ld; id_writes_flag = x.wf; id_reads_flag = x.rf; id_redirect = x.redir;
        pa = producer(x, x.rs_a, x.ua);
        pb = producer(x, x.rs_b, x.ub);
        lu = pipe[0].ld && (pa == 0 || pb == 0);
        fl = x.rf && pipe[0].vld && pipe[0].fw;
        st = lu || fl || (!FWD && (pa >= 0 || pb >= 0));
        e = '{st, st, x.redir && x.valid && !st, m_fa, m_fb, m_perf};
        sb.push_back(e);
        // state after the coming edge
        m_fa = (FWD && !st && pa >= 0) ? pa + 1 : 0;
        m_fb = (FWD && !st && pb >= 0) ? pb + 1 : 0;
        if (st) begin
            tot_stalls++;
            if (m_perf < (1 << PW) - 1) m_perf++;
        end
        s = '{x.valid && !st, x.rd, x.wr, x.ld, x.wf};
        pipe.push_front(s);
        void'(pipe.pop_back());
        last_stall = st;
        last_flush = e.fl;
    endtask

    // Re-present the held ID instruction while the pipeline stalls.
    task automatic issue_held(instr_t x);
        issue(x);
        for (int n = 0; n < 6 && last_stall; n++) issue(x);
    endtask

    task automatic do_reset(int cycles);
        exp_t z = '{0, 0, 0, 0, 0, 0};
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            sb.push_back(z);
        end
        model_clear();
    endtask

    function automatic instr_t mk(bit v, int a, int b, bit ua, bit ub, int rd,
                                  bit wr, bit ld, bit wf, bit rf, bit rdr);
        instr_t x;
        x = '{v, a, b, ua, ub, rd, wr, ld, wf, rf, rdr};
        return x;
    endfunction

    function automatic instr_t rnd();
        instr_t x;
        x.valid = ($urandom_range(99) < 85);
        x.rs_a = $urandom_range(7); x.rs_b = $urandom_range(7); x.rd = $urandom_range(7);
        x.ua = $urandom_range(1); x.ub = $urandom_range(1);
        x.ld = ($urandom_range(99) < 25);
        x.wr = x.ld || ($urandom_range(99) < 60);
        x.wf = ($urandom_range(99) < 30);
        x.rf = ($urandom_range(99) < 20);
        x.redir = ($urandom_range(99) < 15);
        return x;
    endfunction

    instr_t nop, cur;

    initial begin
        model_clear();
        tot_stalls = 0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(2);

        // dependent ALU pairs at distance 1, 2 and 3
        for (int gap = 0; gap < 3; gap++) begin
            issue_held(mk(1, 6, 7, 1, 1, 1, 1, 0, 0, 0, 0));
            for (int g = 0; g < gap; g++) issue_held(mk(1, 6, 7, 1, 1, 5, 1, 0, 0, 0, 0));
            issue_held(mk(1, 1, 6, 1, 1, 4, 1, 0, 0, 0, 0));
            issue(nop); issue(nop); issue(nop);
        end

        // load-use on source B
        issue_held(mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 0, 0));
        issue_held(mk(1, 5, 2, 1, 1, 3, 1, 0, 0, 0, 0));
        issue(nop); issue(nop); issue(nop);

        // flag producer then conditional branch with redirect
        issue_held(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0));
        issue_held(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        issue(nop); issue(nop); issue(nop);

        // self-dependent ADD R3 chain (3 stalls without forwarding)
        issue_held(mk(1, 6, 6, 1, 1, 3, 1, 0, 0, 0, 0));
        issue_held(mk(1, 6, 3, 1, 1, 2, 1, 0, 0, 0, 0));
        issue(nop); issue(nop); issue(nop);

        // non-writing producer / invalid consumer
        issue(mk(1, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0));
        issue(mk(1, 4, 4, 1, 1, 1, 1, 0, 0, 0, 0));
        issue(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0));
        issue(mk(0, 4, 4, 1, 1, 1, 1, 0, 0, 1, 1));
        issue(nop); issue(nop); issue(nop);

        // reset asserted in the middle of a load-use stall
        issue(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        issue(mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 1));
        do_reset(2);
        issue(nop);

        // randomized traffic: hold ID while stalled, kill the slot after a flush
        cur = rnd();
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                cur = rnd();
                if (last_flush) cur.valid = 0;
            end
            issue(cur);
        end

        // saturation of the stall counter
        do_reset(1);
        tot_stalls = 0;
        for (int n = 0; n < 8 * (1 << PW) && tot_stalls < (1 << PW) + 5; n++)
            issue(mk(1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0));
        issue(nop);
        @(negedge clk);
        chk("perf_saturated", 32'(perf_stalls), 32'((1 << PW) - 1));

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
